mac_rr_sched: RTL and testbench

//  Shares one fully pipelined mac_std instance among NREQ requesters. Each cycle, a round-robin

---
 rtl/mac_sched_pkg.sv | 44 ++++
 rtl/mac_std_pkg.sv | 32 +++
 rtl/mac_rr_sched_if.sv | 31 +++
 rtl/mac_std.sv | 131 +++++++++++++
 rtl/rr_arbiter.sv | 45 ++++
 rtl/mac_rr_sched.sv | 151 +++++++++++++++
 tb/tb_mac_rr_sched.sv | 245 ++++++++++++++++++++++++
 7 files changed

// File: rtl/mac_sched_pkg.sv
// rtl/mac_sched_pkg.sv - tag type and round-robin pick shared by the MAC scheduler
package mac_sched_pkg;

    localparam int MAX_NREQ = 64;
    localparam int MAX_IDW  = 6;

    typedef struct packed {
        logic               v;
        logic [MAX_IDW-1:0] id;
    } mac_tag_t;

    typedef struct packed {
        logic               any;
        logic [MAX_IDW-1:0] idx;
    } rr_pick_t;

    function automatic int sched_idw(input int nreq);
        return (nreq > 1) ? $clog2(nreq) : 1;
    endfunction

    // First valid lane scanning ptr, ptr+1, ... modulo nreq; ptr must be below nreq.
    function automatic rr_pick_t rr_pick(input logic [MAX_NREQ-1:0] valid, input int ptr,
                                         input int nreq);
        rr_pick_t           r;
        int                 j;
        logic [MAX_IDW-1:0] jj;
        r = '0;
        for (int k = 0; k < MAX_NREQ; k++) begin
            if (k < nreq) begin
                j = ptr + k;
                if (j >= nreq) begin
                    j = j - nreq;
                end
                jj = MAX_IDW'(j);
                if (!r.any && valid[jj]) begin
                    r.any = 1'b1;
                    r.idx = jj;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/mac_std_pkg.sv
// rtl/mac_std_pkg.sv - E-mode enum and latency/width helpers for the standard MAC
package mac_std_pkg;

    typedef enum logic [1:0] {
        DIS_E = 2'd0,
        ADD_E = 2'd1,
        SUB_E = 2'd2
    } mode_e_t;

    // Pipeline depth: optional input stage, multiplier stage, CSA stage, output stage.
    function automatic int mac_std_lat(input int ff_in_a, input int ff_in_b, input int ff_in_e,
                                       input int ff_mul, input int ff_out,
                                       input int use_csa, input int ff_csa);
        int in_st;
        int csa_st;
        in_st  = (ff_in_a != 0 || ff_in_b != 0 || ff_in_e != 0) ? 1 : 0;
        csa_st = (use_csa != 0 && ff_csa != 0) ? 1 : 0;
        return in_st + ((ff_mul != 0) ? 1 : 0) + csa_st + ((ff_out != 0) ? 1 : 0);
    endfunction

    // Result width: bare product, or a signed sum wide enough for product +/- E.
    function automatic int mac_std_logc(input mode_e_t mode, input int loga, input int logb,
                                        input int loge);
        int pw;
        pw = loga + logb;
        if (mode == DIS_E) begin
            return pw;
        end
        return (((pw + 1) > loge) ? (pw + 1) : loge) + 1;
    endfunction

endpackage

// File: rtl/mac_rr_sched_if.sv
// rtl/mac_rr_sched_if.sv - requester and result bundle of the shared-MAC scheduler
interface mac_rr_sched_if #(
    parameter int NREQ = 4,
    parameter int LOGA = 60,
    parameter int LOGB = 60,
    parameter int LOGE = 32,
    parameter int IDW  = 2,
    parameter int LOGC = 120,
    parameter int CW   = 3
);
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*LOGA-1:0] req_a;
    logic [NREQ*LOGB-1:0] req_b;
    logic [NREQ*LOGE-1:0] req_e;
    logic                 res_valid;
    logic [IDW-1:0]       res_id;
    logic [LOGC-1:0]      res_c;
    logic [CW-1:0]        inflight;
    logic                 idle;

    modport master (
        output req_valid, req_a, req_b, req_e,
        input  req_ready, res_valid, res_id, res_c, inflight, idle
    );

    modport slave (
        input  req_valid, req_a, req_b, req_e,
        output req_ready, res_valid, res_id, res_c, inflight, idle
    );
endinterface

// File: rtl/mac_std.sv
// rtl/mac_std.sv - fully pipelined unsigned A*B with optional signed E add/subtract
module mac_std
    import mac_std_pkg::*;
#(
    parameter int      LOGA    = 60,
    parameter int      LOGB    = 60,
    parameter mode_e_t MODE_E  = DIS_E,
    parameter int      LOGE    = 32,
    parameter int      FF_IN_A = 1,
    parameter int      FF_IN_B = 1,
    parameter int      FF_IN_E = 0,
    parameter int      FF_MUL  = 1,
    parameter int      FF_OUT  = 1,
    parameter int      USE_CSA = 0,
    parameter int      FF_CSA  = 0,
    localparam int     LOGC    = mac_std_logc(MODE_E, LOGA, LOGB, LOGE)
) (
    input  logic            clk,
    input  logic [LOGA-1:0] a,
    input  logic [LOGB-1:0] b,
    input  logic [LOGE-1:0] e,
    output logic [LOGC-1:0] c
);

    localparam int PW     = LOGA + LOGB;
    localparam int IN_ST  = (FF_IN_A != 0 || FF_IN_B != 0 || FF_IN_E != 0) ? 1 : 0;
    localparam int MUL_ST = (FF_MUL != 0) ? 1 : 0;
    localparam int CSA_ST = (USE_CSA != 0 && FF_CSA != 0) ? 1 : 0;
    localparam int OUT_ST = (FF_OUT != 0) ? 1 : 0;
    // E joins after the product, so it is delayed to meet it there.
    localparam int E_DLY  = IN_ST + MUL_ST + CSA_ST;

    logic [LOGA-1:0] a_s;
    logic [LOGB-1:0] b_s;
    logic [PW-1:0]   prod_d;
    logic [PW-1:0]   prod_s;
    logic [PW-1:0]   prod_al;
    logic [LOGE-1:0] e_al;
    logic [LOGC-1:0] sum_d;
    logic            unused_e;

    generate
        if (IN_ST != 0) begin : g_in_ff
            logic [LOGA-1:0] a_q;
            logic [LOGB-1:0] b_q;
            // Register both operands together so they stay aligned.
            always_ff @(posedge clk) begin
                a_q <= a;
                b_q <= b;
            end
            assign a_s = a_q;
            assign b_s = b_q;
        end else begin : g_in_wire
            assign a_s = a;
            assign b_s = b;
        end
    endgenerate

    // Full-width unsigned product.
    always_comb begin
        prod_d = PW'(a_s) * PW'(b_s);
    end

    generate
        if (MUL_ST != 0) begin : g_mul_ff
            logic [PW-1:0] prod_q;
            // Multiplier output register.
            always_ff @(posedge clk) begin
                prod_q <= prod_d;
            end
            assign prod_s = prod_q;
        end else begin : g_mul_wire
            assign prod_s = prod_d;
        end
    endgenerate

    generate
        if (CSA_ST != 0) begin : g_csa_ff
            logic [PW-1:0] prod_c_q;
            // Extra stage ahead of the accumulate adder.
            always_ff @(posedge clk) begin
                prod_c_q <= prod_s;
            end
            assign prod_al = prod_c_q;
        end else begin : g_csa_wire
            assign prod_al = prod_s;
        end
    endgenerate

    generate
        if (E_DLY == 0) begin : g_e_wire
            assign e_al = e;
        end else begin : g_e_dly
            logic [LOGE-1:0] e_q [E_DLY];
            // Shift E along with the product stages.
            always_ff @(posedge clk) begin
                e_q[0] <= e;
                for (int i = 1; i < E_DLY; i++) begin
                    e_q[i] <= e_q[i-1];
                end
            end
            assign e_al = e_q[E_DLY-1];
        end
    endgenerate

    assign unused_e = ^e_al;

    // Product zero-extended, E sign-extended, then combined per mode.
    always_comb begin
        sum_d = LOGC'(prod_al);
        case (MODE_E)
            ADD_E:   sum_d = LOGC'(prod_al) + LOGC'($signed(e_al));
            SUB_E:   sum_d = LOGC'(prod_al) - LOGC'($signed(e_al));
            default: sum_d = LOGC'(prod_al);
        endcase
    end

    generate
        if (OUT_ST != 0) begin : g_out_ff
            logic [LOGC-1:0] sum_q;
            // Result register.
            always_ff @(posedge clk) begin
                sum_q <= sum_d;
            end
            assign c = sum_q;
        end else begin : g_out_wire
            assign c = sum_d;
        end
    endgenerate

endmodule

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin grant with registered priority pointer
module rr_arbiter
    import mac_sched_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = sched_idw(NREQ)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] valid,
    output logic [NREQ-1:0] ready,
    output logic            grant_any,
    output logic [IDW-1:0]  grant_idx
);

    logic [IDW-1:0] ptr_q;
    logic [IDW-1:0] ptr_d;
    rr_pick_t       pick;
    logic           unused_pick;

    // Pick the grantee, gate it with reset, and advance the pointer past it.
    always_comb begin
        pick      = rr_pick(MAX_NREQ'(valid), int'(ptr_q), NREQ);
        grant_any = pick.any & rst_n;
        grant_idx = pick.idx[IDW-1:0];
        ready     = '0;
        ptr_d     = ptr_q;
        if (grant_any) begin
            ready[grant_idx] = 1'b1;
            ptr_d = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + IDW'(1);
        end
    end

    assign unused_pick = ^pick.idx;

    // Pointer register; reset wins over any grant.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/mac_rr_sched.sv
// rtl/mac_rr_sched.sv - round-robin sharing of one pipelined MAC among NREQ requesters
module mac_rr_sched
    import mac_std_pkg::*;
    import mac_sched_pkg::*;
#(
    parameter int      NREQ    = 4,
    parameter int      LOGA    = 60,
    parameter int      LOGB    = 60,
    parameter mode_e_t MODE_E  = DIS_E,
    parameter int      LOGE    = 32,
    parameter int      FF_IN_A = 1,
    parameter int      FF_IN_B = 1,
    parameter int      FF_IN_E = 0,
    parameter int      FF_MUL  = 1,
    parameter int      FF_OUT  = 1,
    parameter int      USE_CSA = 0,
    parameter int      FF_CSA  = 0,
    localparam int     IDW     = sched_idw(NREQ),
    localparam int     LAT     = mac_std_lat(FF_IN_A, FF_IN_B, FF_IN_E, FF_MUL, FF_OUT,
                                             USE_CSA, FF_CSA),
    localparam int     LOGC    = mac_std_logc(MODE_E, LOGA, LOGB, LOGE),
    localparam int     CW      = $clog2(LAT + 2)
) (
    input  logic           clk,
    input  logic           rst_n,
    mac_rr_sched_if.slave  bus
);

    logic            grant_any;
    logic [IDW-1:0]  grant_idx;
    logic [LOGA-1:0] mac_a;
    logic [LOGB-1:0] mac_b;
    logic [LOGE-1:0] mac_e;
    logic [LOGC-1:0] mac_c;
    mac_tag_t        tag_in;
    mac_tag_t        tag_out;
    logic [CW-1:0]   inflight_q;
    logic [CW-1:0]   inflight_d;
    logic            unused_tag_id;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid     (bus.req_valid),
        .ready     (bus.req_ready),
        .grant_any (grant_any),
        .grant_idx (grant_idx)
    );

    // Steer the granted lane onto the MAC; drive zeros when nobody is granted.
    always_comb begin
        mac_a = '0;
        mac_b = '0;
        mac_e = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_any && grant_idx == IDW'(i)) begin
                mac_a = bus.req_a[i*LOGA +: LOGA];
                mac_b = bus.req_b[i*LOGB +: LOGB];
                mac_e = bus.req_e[i*LOGE +: LOGE];
            end
        end
    end

    mac_std #(
        .LOGA    (LOGA),
        .LOGB    (LOGB),
        .MODE_E  (MODE_E),
        .LOGE    (LOGE),
        .FF_IN_A (FF_IN_A),
        .FF_IN_B (FF_IN_B),
        .FF_IN_E (FF_IN_E),
        .FF_MUL  (FF_MUL),
        .FF_OUT  (FF_OUT),
        .USE_CSA (USE_CSA),
        .FF_CSA  (FF_CSA)
    ) u_mac (
        .clk (clk),
        .a   (mac_a),
        .b   (mac_b),
        .e   (mac_e),
        .c   (mac_c)
    );

    // Tag launched alongside the operands.
    always_comb begin
        tag_in    = '0;
        tag_in.v  = grant_any;
        tag_in.id = MAX_IDW'(grant_idx);
    end

    generate
        if (LAT == 0) begin : g_tag_wire
            assign tag_out = tag_in;
        end else begin : g_tag_pipe
            mac_tag_t tag_q [LAT];
            mac_tag_t tag_d [LAT];

            // Shift every cycle in lockstep with the MAC pipeline.
            always_comb begin
                tag_d[0] = tag_in;
                for (int i = 1; i < LAT; i++) begin
                    tag_d[i] = tag_q[i-1];
                end
            end

            // Reset drops every in-flight tag; the MAC data is masked by them.
            always_ff @(posedge clk) begin
                for (int i = 0; i < LAT; i++) begin
                    if (!rst_n) begin
                        tag_q[i] <= '0;
                    end else begin
                        tag_q[i] <= tag_d[i];
                    end
                end
            end

            assign tag_out = tag_q[LAT-1];
        end
    endgenerate

    assign unused_tag_id = ^tag_out.id;

    // Count issues minus returns; a simultaneous pair leaves the count unchanged.
    always_comb begin
        inflight_d = inflight_q;
        if (grant_any && !tag_out.v) begin
            inflight_d = inflight_q + CW'(1);
        end else if (!grant_any && tag_out.v) begin
            inflight_d = inflight_q - CW'(1);
        end
    end

    // Outstanding-request counter register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            inflight_q <= '0;
        end else begin
            inflight_q <= inflight_d;
        end
    end

    assign bus.res_valid = tag_out.v;
    assign bus.res_id    = tag_out.id[IDW-1:0];
    assign bus.res_c     = mac_c;
    assign bus.inflight  = inflight_q;
    assign bus.idle      = (inflight_q == '0) && (bus.req_valid == '0);

endmodule

// File: tb/tb_mac_rr_sched.sv
// tb/tb_mac_rr_sched.sv - directed self-checking bench for mac_rr_sched
module tb_mac_rr_sched;
    import mac_std_pkg::*;

    localparam int NREQ   = 4;
    localparam int LOGA   = 60;
    localparam int LOGB   = 60;
    localparam int LOGE   = 32;
    localparam int IDW    = 2;
    localparam int LAT    = 3;
    localparam int LOGC   = 120;
    localparam int LOGC_S = 122;
    localparam int CW     = 3;

    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    mac_rr_sched_if #(.NREQ(NREQ), .LOGA(LOGA), .LOGB(LOGB), .LOGE(LOGE), .IDW(IDW),
                      .LOGC(LOGC), .CW(CW)) bus ();
    mac_rr_sched_if #(.NREQ(NREQ), .LOGA(LOGA), .LOGB(LOGB), .LOGE(LOGE), .IDW(IDW),
                      .LOGC(LOGC_S), .CW(CW)) sbus ();

    mac_rr_sched #(.NREQ(NREQ), .LOGA(LOGA), .LOGB(LOGB), .MODE_E(DIS_E), .LOGE(LOGE))
        dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    mac_rr_sched #(.NREQ(NREQ), .LOGA(LOGA), .LOGB(LOGB), .MODE_E(SUB_E), .LOGE(LOGE))
        dut_sub (.clk(clk), .rst_n(rst_n), .bus(sbus));

    typedef struct {
        logic        rst_n;
        logic [3:0]  valid;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  ready;
        logic        rv;
        logic [1:0]  id;
        logic [15:0] c;
        logic [2:0]  infl;
        logic        idl;
    } vec_t;

    vec_t vecs [16];

    function automatic vec_t mk(input logic r, input logic [3:0] v, input logic [31:0] a,
                                input logic [31:0] b, input logic [3:0] rdy, input logic rv,
                                input logic [1:0] id, input logic [15:0] c,
                                input logic [2:0] infl, input logic idl);
        vec_t x;
        x.rst_n = r;   x.valid = v;  x.a = a;   x.b = b;
        x.ready = rdy; x.rv = rv;    x.id = id; x.c = c;
        x.infl = infl; x.idl = idl;
        return x;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One cycle on the main bus: inputs change 1 after the edge, sampling 4 after.
    task automatic drive(input logic r, input logic [3:0] v, input logic [31:0] a,
                         input logic [31:0] b);
        @(posedge clk);
        #1;
        rst_n = r;
        bus.req_valid = v;
        for (int i = 0; i < NREQ; i++) begin
            bus.req_a[i*LOGA +: LOGA] = LOGA'(a[i*8 +: 8]);
            bus.req_b[i*LOGB +: LOGB] = LOGB'(b[i*8 +: 8]);
        end
        #3;
    endtask

    // One cycle on the SUB_E instance, lane 0 only.
    task automatic sdrive(input logic v, input logic [7:0] a, input logic [7:0] b,
                          input logic [31:0] e);
        @(posedge clk);
        #1;
        sbus.req_valid = {3'b000, v};
        sbus.req_a[0 +: LOGA] = LOGA'(a);
        sbus.req_b[0 +: LOGB] = LOGB'(b);
        sbus.req_e[0 +: LOGE] = e;
        #3;
    endtask

    initial begin
        int                last_g [4];
        int                exp_k;
        int                peak;
        logic              got;
        logic [3:0]        exp_rdy;
        logic [LOGC_S-1:0] exp_neg;

        rst_n          = 1'b0;
        bus.req_valid  = '0;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.req_e      = '0;
        sbus.req_valid = '0;
        sbus.req_a     = '0;
        sbus.req_b     = '0;
        sbus.req_e     = '0;

        // single request on lane 2, then four-way contention starting from ptr 0
        vecs[0]  = mk(0, 4'b0000, 32'h0,        32'h0,        4'b0000, 0, 0, 0,  0, 0);
        vecs[1]  = mk(1, 4'b0000, 32'h0,        32'h0,        4'b0000, 0, 0, 0,  0, 1);
        vecs[2]  = mk(1, 4'b0100, 32'h00030000, 32'h00050000, 4'b0100, 0, 0, 0,  0, 0);
        vecs[3]  = mk(1, 4'b0000, 32'h0,        32'h0,        4'b0000, 0, 0, 0,  1, 0);
        vecs[4]  = mk(1, 4'b0000, 32'h0,        32'h0,        4'b0000, 0, 0, 0,  1, 0);
        vecs[5]  = mk(1, 4'b0000, 32'h0,        32'h0,        4'b0000, 1, 2, 15, 1, 0);
        vecs[6]  = mk(1, 4'b0000, 32'h0,        32'h0,        4'b0000, 0, 0, 0,  0, 1);
        vecs[7]  = mk(0, 4'b0000, 32'h0,        32'h0,        4'b0000, 0, 0, 0,  0, 0);
        vecs[8]  = mk(1, 4'b1111, 32'h04030201, 32'h0A0A0A0A, 4'b0001, 0, 0, 0,  0, 0);
        vecs[9]  = mk(1, 4'b1110, 32'h04030201, 32'h0A0A0A0A, 4'b0010, 0, 0, 0,  1, 0);
        vecs[10] = mk(1, 4'b1100, 32'h04030201, 32'h0A0A0A0A, 4'b0100, 0, 0, 0,  2, 0);
        vecs[11] = mk(1, 4'b1000, 32'h04030201, 32'h0A0A0A0A, 4'b1000, 1, 0, 10, 3, 0);
        vecs[12] = mk(1, 4'b0000, 32'h0,        32'h0,        4'b0000, 1, 1, 20, 3, 0);
        vecs[13] = mk(1, 4'b0000, 32'h0,        32'h0,        4'b0000, 1, 2, 30, 2, 0);
        vecs[14] = mk(1, 4'b0000, 32'h0,        32'h0,        4'b0000, 1, 3, 40, 1, 0);
        vecs[15] = mk(1, 4'b0000, 32'h0,        32'h0,        4'b0000, 0, 0, 0,  0, 1);

        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].rst_n, vecs[i].valid, vecs[i].a, vecs[i].b);
            chk($sformatf("v%0d.ready", i), bus.req_ready, vecs[i].ready);
            if (vecs[i].rst_n) begin
                chk($sformatf("v%0d.res_valid", i), bus.res_valid, vecs[i].rv);
                chk($sformatf("v%0d.inflight", i), bus.inflight, vecs[i].infl);
                chk($sformatf("v%0d.idle", i), bus.idle, vecs[i].idl);
                if (vecs[i].rv) begin
                    chk($sformatf("v%0d.res_id", i), bus.res_id, vecs[i].id);
                    chk($sformatf("v%0d.res_c", i), bus.res_c, vecs[i].c);
                end
            end
        end

        // fairness: steer ptr to 2 through one grant on lane 1, then lanes 1 and 3 compete
        drive(0, 4'b0000, 32'h0, 32'h0);
        drive(1, 4'b0010, 32'h0, 32'h0);
        chk("fair.setup", bus.req_ready, 4'b0010);
        last_g = '{-10, -10, -10, -10};
        for (int k = 0; k < 4; k++) begin
            drive(1, 4'b1010, 32'h0, 32'h0);
            exp_rdy = (k % 2 == 0) ? 4'b1000 : 4'b0010;
            chk($sformatf("fair.grant%0d", k), bus.req_ready, exp_rdy);
            for (int l = 0; l < 4; l++) begin
                if (bus.req_ready[l]) begin
                    if (last_g[l] >= 0) begin
                        chk($sformatf("fair.gap%0d", l), k - last_g[l], 2);
                    end
                    last_g[l] = k;
                end
            end
        end
        for (int k = 0; k < LAT + 2; k++) begin
            drive(1, 4'b0000, 32'h0, 32'h0);
        end
        chk("fair.drained", bus.inflight, 0);

        // throughput: lane 0 streams A=B=k for k=1..8
        drive(0, 4'b0000, 32'h0, 32'h0);
        exp_k = 1;
        peak  = 0;
        for (int cyc = 0; cyc < 8 + LAT + 3; cyc++) begin
            if (cyc < 8) begin
                drive(1, 4'b0001, 32'(cyc + 1), 32'(cyc + 1));
                chk("tp.ready", bus.req_ready, 4'b0001);
            end else begin
                drive(1, 4'b0000, 32'h0, 32'h0);
            end
            if (int'(bus.inflight) > peak) begin
                peak = int'(bus.inflight);
            end
            if (bus.res_valid) begin
                chk("tp.res_id", bus.res_id, 0);
                chk("tp.res_c", bus.res_c, exp_k * exp_k);
                chk("tp.when", cyc, LAT + exp_k - 1);
                exp_k++;
            end
        end
        chk("tp.count", exp_k - 1, 8);
        chk("tp.peak", peak, LAT);

        // reset while three requests from lane 2 are still in the pipe
        drive(0, 4'b0000, 32'h0, 32'h0);
        for (int k = 0; k < 3; k++) begin
            drive(1, 4'b0100, 32'h00020000, 32'h00020000);
        end
        drive(0, 4'b0000, 32'h0, 32'h0);
        for (int k = 0; k < 6; k++) begin
            drive(1, 4'b0000, 32'h0, 32'h0);
            chk($sformatf("rst.nores%0d", k), bus.res_valid, 0);
            if (k == 0) begin
                chk("rst.inflight", bus.inflight, 0);
                chk("rst.idle", bus.idle, 1);
            end
        end
        drive(1, 4'b1111, 32'h0, 32'h0);
        chk("rst.ptr0", bus.req_ready, 4'b0001);
        for (int k = 0; k < LAT + 2; k++) begin
            drive(1, 4'b0000, 32'h0, 32'h0);
        end

        // SUB_E: 7*6-(-10)=52, then 7*6-100=-58
        sdrive(1'b1, 8'd7, 8'd6, 32'hFFFF_FFF6);
        chk("sub.ready", sbus.req_ready, 4'b0001);
        got = 1'b0;
        for (int k = 0; k < 8 && !got; k++) begin
            sdrive(1'b0, 8'd0, 8'd0, 32'h0);
            if (sbus.res_valid) begin
                got = 1'b1;
                chk("sub.pos_c", sbus.res_c, 52);
                chk("sub.pos_lat", k, LAT - 1);
            end
        end
        if (!got) begin
            chk("sub.pos_timeout", 0, 1);
        end

        exp_neg = '0 - LOGC_S'(58);
        sdrive(1'b1, 8'd7, 8'd6, 32'd100);
        got = 1'b0;
        for (int k = 0; k < 8 && !got; k++) begin
            sdrive(1'b0, 8'd0, 8'd0, 32'h0);
            if (sbus.res_valid) begin
                got = 1'b1;
                chk("sub.neg_c", sbus.res_c, 128'(exp_neg));
                chk("sub.neg_id", sbus.res_id, 0);
            end
        end
        if (!got) begin
            chk("sub.neg_timeout", 0, 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
